// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle controller: opcode/funct values,
// FSM state encoding, steering-field encodings, the instruction-class enum
// and the packed bundle of datapath steering signals.
// ---------------------------------------------------------------------------
package ctrl_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_NOP   = 6'h00;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_OR  = 3'd2;

   localparam logic [1:0] EXT_ZERO = 2'd0;
   localparam logic [1:0] EXT_SIGN = 2'd1;
   localparam logic [1:0] EXT_LUI  = 2'd2;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_DM  = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef enum logic [3:0] {
      C_ADDU, C_SUBU, C_JR, C_NOP, C_ORI, C_LW,
      C_SW, C_BEQ, C_LUI, C_J, C_JAL, C_ILLEGAL
   } iclass_t;

   typedef struct packed {
      logic [1:0] regdst;
      logic       branch0;
      logic       branch1;
      logic       branch2;
      logic [1:0] memtoreg;
      logic [2:0] aluop;
      logic       alusrc;
      logic [1:0] sign;
   } steer_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Option/Function interface between datapath and controller.
//   master : datapath side, drives Option/Function, consumes controls.
//   slave  : controller side, consumes Option/Function, drives controls.
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if;
   logic [5:0] Option;
   logic [5:0] Function;
   logic       IRWrite;
   logic       PCWrite;
   logic [1:0] Regdst;
   logic       Branch0;
   logic       Branch1;
   logic       Branch2;
   logic       MemRead;
   logic [1:0] MemtoReg;
   logic [2:0] ALUOp;
   logic       MemWrite;
   logic       ALUSrc;
   logic       Regwrite;
   logic [1:0] Sign;

   modport master (
      output Option, Function,
      input  IRWrite, PCWrite, Regdst, Branch0, Branch1, Branch2, MemRead,
             MemtoReg, ALUOp, MemWrite, ALUSrc, Regwrite, Sign
   );

   modport slave (
      input  Option, Function,
      output IRWrite, PCWrite, Regdst, Branch0, Branch1, Branch2, MemRead,
             MemtoReg, ALUOp, MemWrite, ALUSrc, Regwrite, Sign
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
// Purely combinational: classifies an opcode/funct pair and produces the
// datapath steering bundle for that class.
//   op, fn : opcode and function field
//   cls    : instruction class (C_ILLEGAL when undecodable)
//   steer  : Regdst/Branch*/MemtoReg/ALUOp/ALUSrc/Sign for the class
// ---------------------------------------------------------------------------
module mc_ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] fn,
   output iclass_t    cls,
   output steer_t     steer
);

   always_comb begin
      // NOTE: default first so every path assigns cls; no latch is inferred.
      cls = C_ILLEGAL;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADDU: cls = C_ADDU;
               FN_SUBU: cls = C_SUBU;
               FN_JR:   cls = C_JR;
               FN_NOP:  cls = C_NOP;
               default: cls = C_ILLEGAL;
            endcase
         end
         OP_ORI:  cls = C_ORI;
         OP_LW:   cls = C_LW;
         OP_SW:   cls = C_SW;
         OP_BEQ:  cls = C_BEQ;
         OP_LUI:  cls = C_LUI;
         OP_J:    cls = C_J;
         OP_JAL:  cls = C_JAL;
         default: cls = C_ILLEGAL;
      endcase
   end

   always_comb begin
      steer = '0;
      case (cls)
         C_ADDU: begin steer.regdst = DST_RD; steer.aluop = ALU_ADD; end
         C_SUBU: begin steer.regdst = DST_RD; steer.aluop = ALU_SUB; end
         C_ORI: begin
            steer.alusrc = 1'b1; steer.sign = EXT_ZERO; steer.aluop = ALU_OR;
         end
         C_LUI: begin
            steer.alusrc = 1'b1; steer.sign = EXT_LUI; steer.aluop = ALU_ADD;
         end
         C_LW: begin
            steer.alusrc   = 1'b1; steer.sign = EXT_SIGN; steer.aluop = ALU_ADD;
            steer.memtoreg = WB_DM;
         end
         C_SW: begin
            steer.alusrc = 1'b1; steer.sign = EXT_SIGN; steer.aluop = ALU_ADD;
         end
         C_BEQ: begin
            steer.branch0 = 1'b1; steer.aluop = ALU_SUB; steer.sign = EXT_SIGN;
         end
         C_J:   steer.branch1 = 1'b1;
         C_JAL: begin
            // Link write of pc+4 into $31 happens in the same cycle as the jump.
            steer.branch1 = 1'b1; steer.regdst = DST_RA; steer.memtoreg = WB_PC4;
         end
         C_JR:  steer.branch2 = 1'b1;
         default: steer = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives all datapath controls.
//   clk, reset : clock and synchronous active-high reset
//   bus        : Option/Function in, datapath controls out (slave side)
//   state_o    : current state, for debug
//   instr_done : one-cycle pulse in the retire cycle
//   instr_cnt  : retired-instruction counter (wraps)
//   illegal    : sticky undecodable-instruction flag, cleared by reset only
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   mc_ctrl_fsm_if.slave     bus,
   output logic [2:0]       state_o,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_cnt,
   output logic             illegal
);

   state_t     state;
   logic [5:0] op_q, fn_q;
   logic [5:0] dec_op, dec_fn;
   iclass_t    cls;
   steer_t     steer, steer_o;
   logic       ir_w, pc_w, mem_rd, mem_wr, reg_wr;
   logic       short_op;

   // In DECODE the decoder looks at the live IR fields so illegal can be
   // flagged on the DECODE edge; afterwards it sees the latched copy, which
   // makes later Option/Function changes irrelevant.
   assign dec_op = (state == S_DECODE) ? bus.Option   : op_q;
   assign dec_fn = (state == S_DECODE) ? bus.Function : fn_q;

   mc_ctrl_decode u_decode (
      .op    (dec_op),
      .fn    (dec_fn),
      .cls   (cls),
      .steer (steer)
   );

   assign short_op = (cls inside {C_BEQ, C_J, C_JR, C_NOP, C_ILLEGAL});

   // Strobes are gated by reset so an instruction interrupted by reset can
   // never commit a write in the reset cycle.
   always_comb begin
      ir_w   = 1'b0;
      pc_w   = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      reg_wr = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: ir_w = 1'b1;
            S_EXEC: begin
               if (short_op) begin
                  pc_w = 1'b1;
               end else if (cls == C_JAL) begin
                  pc_w   = 1'b1;
                  reg_wr = 1'b1;
               end
            end
            S_MEM: begin
               if (cls == C_LW) begin
                  mem_rd = 1'b1;
               end else if (cls == C_SW) begin
                  mem_wr = 1'b1;
                  pc_w   = 1'b1;
               end
            end
            S_WB: begin
               reg_wr = 1'b1;
               pc_w   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Steering is only meaningful once op_q holds the instruction.
   assign steer_o = (state inside {S_EXEC, S_MEM, S_WB}) ? steer : '0;

   assign bus.IRWrite  = ir_w;
   assign bus.PCWrite  = pc_w;
   assign bus.MemRead  = mem_rd;
   assign bus.MemWrite = mem_wr;
   assign bus.Regwrite = reg_wr;
   assign bus.Regdst   = steer_o.regdst;
   assign bus.Branch0  = steer_o.branch0;
   assign bus.Branch1  = steer_o.branch1;
   assign bus.Branch2  = steer_o.branch2;
   assign bus.MemtoReg = steer_o.memtoreg;
   assign bus.ALUOp    = steer_o.aluop;
   assign bus.ALUSrc   = steer_o.alusrc;
   assign bus.Sign     = steer_o.sign;

   // Every instruction retires in the cycle it commits the PC.
   assign instr_done = pc_w;
   assign state_o    = state;

   // NOTE: sequential state uses <= only, so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         op_q      <= '0;
         fn_q      <= '0;
         instr_cnt <= '0;
         illegal   <= 1'b0;
      end else begin
         if (pc_w) instr_cnt <= instr_cnt + CNT_W'(1);
         case (state)
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               op_q  <= bus.Option;
               fn_q  <= bus.Function;
               if (cls == C_ILLEGAL) illegal <= 1'b1;
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (cls)
                  C_LW, C_SW:                  state <= S_MEM;
                  C_ADDU, C_SUBU, C_ORI, C_LUI: state <= S_WB;
                  default:                     state <= S_FETCH;
               endcase
            end
            S_MEM:   state <= (cls == C_LW) ? S_WB : S_FETCH;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Table-driven check of the multi-cycle controller: each record gives the
// opcode/funct, latency, expected state and strobe per cycle, and expected
// steering bundle. Hand-written sequences cover reset, mid-MEM reset and
// counter wrap (counter built narrow so the wrap is reachable).
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       state_o;
   logic             instr_done;
   logic [CNT_W-1:0] instr_cnt;
   logic             illegal;

   mc_ctrl_fsm_if bus ();

   mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .state_o    (state_o),
      .instr_done (instr_done),
      .instr_cnt  (instr_cnt),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // Strobe order: {IRWrite, PCWrite, MemRead, MemWrite, Regwrite}
   typedef struct {
      string                 name;
      logic [5:0]            op;
      logic [5:0]            fn;
      int                    lat;
      logic [0:4][2:0]       seq;
      logic [0:4][4:0]       stb;
      logic [12:0]           steer;
      logic                  ill;
   } vec_t;

   int               n_cmp = 0;
   int               n_err = 0;
   logic             exp_ill;
   logic [CNT_W-1:0] exp_cnt;
   vec_t             vecs[13];

   function automatic logic [12:0] mk(input logic [1:0] rd, input logic b0,
                                      input logic b1, input logic b2,
                                      input logic [1:0] m2r, input logic [2:0] alu,
                                      input logic src, input logic [1:0] sgn);
      return {rd, b0, b1, b2, m2r, alu, src, sgn};
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] strobes();
      return {bus.IRWrite, bus.PCWrite, bus.MemRead, bus.MemWrite, bus.Regwrite};
   endfunction

   function automatic logic [12:0] steering();
      return {bus.Regdst, bus.Branch0, bus.Branch1, bus.Branch2, bus.MemtoReg,
              bus.ALUOp, bus.ALUSrc, bus.Sign};
   endfunction

   // Entered just after the edge that starts FETCH. Option/Function carry
   // junk everywhere except the DECODE cycle.
   task automatic run_vec(input vec_t v);
      bus.Option   = ~v.op;
      bus.Function = ~v.fn;
      for (int c = 0; c < v.lat; c++) begin
         if (c == 1) begin bus.Option = v.op;  bus.Function = v.fn;  end
         if (c == 2) begin bus.Option = ~v.op; bus.Function = ~v.fn; end
         if (c >= 2 && v.ill) exp_ill = 1'b1;
         @(negedge clk);
         check($sformatf("%s c%0d state", v.name, c), 32'(state_o), 32'(v.seq[c]));
         check($sformatf("%s c%0d strobes", v.name, c), 32'(strobes()), 32'(v.stb[c]));
         check($sformatf("%s c%0d done", v.name, c), 32'(instr_done), 32'(v.stb[c][3]));
         check($sformatf("%s c%0d steer", v.name, c), 32'(steering()),
               (c < 2) ? 32'd0 : 32'(v.steer));
         check($sformatf("%s c%0d illegal", v.name, c), 32'(illegal), 32'(exp_ill));
         if (c == 0)
            check($sformatf("%s cnt", v.name), 32'(instr_cnt), 32'(exp_cnt));
         @(posedge clk); #1;
      end
      exp_cnt = exp_cnt + 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           name    op     fn     lat  seq               strobes per cycle                                   steer                       ill
      vecs[0]  = '{"LW",   6'h23, 6'h00, 5, {3'd0,3'd1,3'd2,3'd3,3'd4}, {5'b10000,5'b00000,5'b00000,5'b00100,5'b01001}, mk(0,0,0,0,1,0,1,1), 1'b0};
      vecs[1]  = '{"SW",   6'h2B, 6'h00, 4, {3'd0,3'd1,3'd2,3'd3,3'd0}, {5'b10000,5'b00000,5'b00000,5'b01010,5'b00000}, mk(0,0,0,0,0,0,1,1), 1'b0};
      vecs[2]  = '{"BEQ",  6'h04, 6'h00, 3, {3'd0,3'd1,3'd2,3'd0,3'd0}, {5'b10000,5'b00000,5'b01000,5'b00000,5'b00000}, mk(0,1,0,0,0,1,0,1), 1'b0};
      vecs[3]  = '{"JAL",  6'h03, 6'h00, 3, {3'd0,3'd1,3'd2,3'd0,3'd0}, {5'b10000,5'b00000,5'b01001,5'b00000,5'b00000}, mk(2,0,1,0,2,0,0,0), 1'b0};
      vecs[4]  = '{"ADDU", 6'h00, 6'h21, 4, {3'd0,3'd1,3'd2,3'd4,3'd0}, {5'b10000,5'b00000,5'b00000,5'b01001,5'b00000}, mk(1,0,0,0,0,0,0,0), 1'b0};
      vecs[5]  = '{"SUBU", 6'h00, 6'h23, 4, {3'd0,3'd1,3'd2,3'd4,3'd0}, {5'b10000,5'b00000,5'b00000,5'b01001,5'b00000}, mk(1,0,0,0,0,1,0,0), 1'b0};
      vecs[6]  = '{"ORI",  6'h0D, 6'h00, 4, {3'd0,3'd1,3'd2,3'd4,3'd0}, {5'b10000,5'b00000,5'b00000,5'b01001,5'b00000}, mk(0,0,0,0,0,2,1,0), 1'b0};
      vecs[7]  = '{"LUI",  6'h0F, 6'h00, 4, {3'd0,3'd1,3'd2,3'd4,3'd0}, {5'b10000,5'b00000,5'b00000,5'b01001,5'b00000}, mk(0,0,0,0,0,0,1,2), 1'b0};
      vecs[8]  = '{"J",    6'h02, 6'h00, 3, {3'd0,3'd1,3'd2,3'd0,3'd0}, {5'b10000,5'b00000,5'b01000,5'b00000,5'b00000}, mk(0,0,1,0,0,0,0,0), 1'b0};
      vecs[9]  = '{"JR",   6'h00, 6'h08, 3, {3'd0,3'd1,3'd2,3'd0,3'd0}, {5'b10000,5'b00000,5'b01000,5'b00000,5'b00000}, mk(0,0,0,1,0,0,0,0), 1'b0};
      vecs[10] = '{"NOP",  6'h00, 6'h00, 3, {3'd0,3'd1,3'd2,3'd0,3'd0}, {5'b10000,5'b00000,5'b01000,5'b00000,5'b00000}, 13'd0,               1'b0};
      vecs[11] = '{"ILL",  6'h3F, 6'h00, 3, {3'd0,3'd1,3'd2,3'd0,3'd0}, {5'b10000,5'b00000,5'b01000,5'b00000,5'b00000}, 13'd0,               1'b1};
      vecs[12] = vecs[4];
      vecs[12].name = "ADDU2";

      exp_ill      = 1'b0;
      exp_cnt      = '0;
      reset        = 1'b1;
      bus.Option   = 6'h23;
      bus.Function = 6'h00;

      // Reset held for three edges; strobes must stay low while it is high.
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("reset strobes", 32'(strobes()), 32'd0);
      check("reset done", 32'(instr_done), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Main table; the first record begins in the first post-reset FETCH.
      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      // Reset asserted during MEM of an SW: no write, back to FETCH, cleared.
      bus.Option = 6'h2B; bus.Function = 6'h00;
      @(posedge clk); #1;                    // now DECODE
      @(posedge clk); #1;                    // now EXEC
      @(posedge clk); #1;                    // now MEM
      reset = 1'b1;
      @(negedge clk);
      check("midrst state", 32'(state_o), 32'd3);
      check("midrst strobes", 32'(strobes()), 32'd0);
      check("midrst illegal still set", 32'(illegal), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("postrst state", 32'(state_o), 32'd0);
      check("postrst cnt", 32'(instr_cnt), 32'd0);
      check("postrst illegal", 32'(illegal), 32'd0);
      check("postrst strobes", 32'(strobes()), 32'b10000);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_ill = 1'b0;
      exp_cnt = '0;

      // Counter wrap: 15 NOPs reach the top value, one more wraps to zero.
      for (int i = 0; i < 15; i++) run_vec(vecs[10]);
      check("cnt at max", 32'(instr_cnt), 32'd15);
      run_vec(vecs[10]);
      check("cnt wrapped", 32'(instr_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
